// File: rtl/md4_msg_padder.sv
// md4_msg_padder: streaming MD4 message pre-processor.
// Packs a byte stream into 512-bit little-endian blocks and appends MD4 padding
// (0x80, zero fill, 64-bit little-endian bit length).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/keep/last     source byte beat (keep=0 with last ends the message without a byte)
//   in_valid/in_ready     source handshake
//   blk_data              512-bit block, byte k at [8k+7:8k]
//   blk_first/blk_last    first block of message / final length-bearing block
//   blk_valid/blk_ready   block handshake
module md4_msg_padder #(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned BLK_W = 512;

  localparam logic [1:0] S_ACCEPT     = 2'd0;
  localparam logic [1:0] S_EMIT_DATA  = 2'd1;
  localparam logic [1:0] S_EMIT_PAD1  = 2'd2;
  localparam logic [1:0] S_EMIT_FINAL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] buf_q, buf_d;
  logic             first_q, first_d;
  logic             pend_last_q, pend_last_d;
  logic             in_ready_q, in_ready_d;
  logic             blk_valid_q, blk_valid_d;
  logic             blk_first_q, blk_first_d;
  logic             blk_last_q, blk_last_d;

  logic             in_fire;
  logic             blk_fire;
  logic [IDX_W:0]   fill;
  logic [CNT_W-1:0] cnt_inc;

  // Message bit count, zero-extended or truncated to the 64-bit length field.
  function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
    logic [CNT_W+2:0] b;
    b = {c, 3'b000};
    return 64'(b);
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACCEPT;
      idx_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      first_q     <= 1'b1;
      pend_last_q <= 1'b0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      first_q     <= first_d;
      pend_last_q <= pend_last_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
    end
  end

  // Next-state, buffer update and padding.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    first_d     = first_q;
    pend_last_d = pend_last_q;

    in_fire  = in_valid & in_ready_q;
    blk_fire = blk_valid_q & blk_ready;
    // Bytes held after this beat; bit 6 set means the block just filled.
    fill     = {1'b0, idx_q} + (IDX_W+1)'(in_keep);
    cnt_inc  = cnt_q + CNT_W'(in_keep);

    case (state_q)
      S_ACCEPT: begin
        if (in_fire) begin
          if (in_keep) begin
            buf_d[{idx_q, 3'b000} +: 8] = in_data;
            idx_d = idx_q + 6'd1;
            cnt_d = cnt_inc;
          end
          if (fill[IDX_W]) begin
            state_d     = S_EMIT_DATA;
            pend_last_d = in_last;
          end else if (in_last) begin
            // Bytes above the fill point are already zero: the buffer is cleared
            // whenever a block leaves.
            buf_d[{fill[IDX_W-1:0], 3'b000} +: 8] = 8'h80;
            if (fill <= 7'd55) begin
              buf_d[511:448] = bit_len(cnt_inc);
              state_d        = S_EMIT_FINAL;
            end else begin
              state_d = S_EMIT_PAD1;
            end
          end
        end
      end
      S_EMIT_DATA: begin
        if (blk_fire) begin
          first_d     = 1'b0;
          pend_last_d = 1'b0;
          buf_d       = '0;
          if (pend_last_q) begin
            buf_d[7:0]     = 8'h80;
            buf_d[511:448] = bit_len(cnt_q);
            state_d        = S_EMIT_FINAL;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_EMIT_PAD1: begin
        if (blk_fire) begin
          first_d        = 1'b0;
          buf_d          = '0;
          buf_d[511:448] = bit_len(cnt_q);
          state_d        = S_EMIT_FINAL;
        end
      end
      default: begin
        if (blk_fire) begin
          buf_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = S_ACCEPT;
        end
      end
    endcase

    in_ready_d  = (state_d == S_ACCEPT);
    blk_valid_d = (state_d != S_ACCEPT);
    blk_first_d = blk_valid_d & first_d;
    blk_last_d  = (state_d == S_EMIT_FINAL);
  end

  assign in_ready  = in_ready_q;
  assign blk_data  = buf_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;
  assign blk_valid = blk_valid_q;

endmodule

// File: tb/tb_md4_msg_padder.sv
// Self-checking bench for md4_msg_padder: random messages against a padding model.
module tb_md4_msg_padder;

  typedef logic [7:0] byte_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_keep = 1'b0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] exp_q[$];

  md4_msg_padder #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // Reference: standard MD4 padding of the whole message, split into 64-byte blocks.
  task automatic model(input byte_t msg[$]);
    byte_t p[$];
    logic [63:0] bitlen;
    logic [511:0] blk;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bitlen[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int k = 0; k < 64; k++) blk[8*k +: 8] = p[64*b + k];
      exp_q.push_back(blk);
    end
  endtask

  // One source beat; called right after a falling edge, returns after the next one.
  task automatic beat(input byte_t d, input logic k, input logic l);
    int cyc;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
  endtask

  // Drive a message and collect its blocks against the model, with random backpressure.
  task automatic run_msg(input byte_t msg[$], input bit term_sep, input int bp_pct, input int ill_pct);
    int nb;
    bit sep;
    model(msg);
    nb  = exp_q.size();
    sep = term_sep || (msg.size() == 0);
    fork
      begin
        for (int i = 0; i < msg.size(); i++) begin
          if ($urandom_range(99) < ill_pct) beat(byte_t'($urandom_range(255)), 1'b0, 1'b0);
          beat(msg[i], 1'b1, (!sep && i == msg.size() - 1));
        end
        if (sep) beat(8'h00, 1'b0, 1'b1);
      end
      begin
        for (int b = 0; b < nb; b++) begin
          bit got;
          int cyc;
          got = 0;
          cyc = 0;
          while (!got && cyc < 3000) begin
            blk_ready = ($urandom_range(99) < bp_pct) ? 1'b0 : 1'b1;
            if (blk_valid && blk_ready) begin
              got = 1;
              n_checks += 3;
              if (blk_data !== exp_q[b]) begin
                n_fail++;
                $display("FAIL blk_data len=%0d blk=%0d: got %h required %h", msg.size(), b, blk_data, exp_q[b]);
              end
              if (blk_first !== (b == 0)) begin
                n_fail++;
                $display("FAIL blk_first len=%0d blk=%0d: got %b required %b", msg.size(), b, blk_first, (b == 0));
              end
              if (blk_last !== (b == nb - 1)) begin
                n_fail++;
                $display("FAIL blk_last len=%0d blk=%0d: got %b required %b", msg.size(), b, blk_last, (b == nb - 1));
              end
            end
            @(negedge clk);
            cyc++;
          end
          blk_ready = 1'b0;
          if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL blk_timeout len=%0d blk=%0d: got none required block", msg.size(), b);
          end
        end
      end
    join
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks += 5;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready: got %b required 0", tag, in_ready); end
    if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL %s blk_valid: got %b required 0", tag, blk_valid); end
    if (blk_first !== 1'b0) begin n_fail++; $display("FAIL %s blk_first: got %b required 0", tag, blk_first); end
    if (blk_last !== 1'b0) begin n_fail++; $display("FAIL %s blk_last: got %b required 0", tag, blk_last); end
    if (blk_data !== 512'd0) begin n_fail++; $display("FAIL %s blk_data: got %h required 0", tag, blk_data); end
  endtask

  task automatic test_reset();
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_empty();
    byte_t m[$];
    run_msg(m, 1'b1, 0, 0);
  endtask

  task automatic test_abc();
    logic [511:0] abc_blk;
    abc_blk = '0;
    abc_blk[31:0]    = 32'h80636261;
    abc_blk[455:448] = 8'h18;
    beat(8'h61, 1'b1, 1'b0);
    beat(8'h62, 1'b1, 1'b0);
    n_checks++;
    if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL abc_early_valid: got %b required 0", blk_valid); end
    beat(8'h63, 1'b1, 1'b1);
    n_checks += 4;
    if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL abc_latency: blk_valid got %b required 1", blk_valid); end
    if (blk_data !== abc_blk) begin n_fail++; $display("FAIL abc_data: got %h required %h", blk_data, abc_blk); end
    if (blk_first !== 1'b1) begin n_fail++; $display("FAIL abc_first: got %b required 1", blk_first); end
    if (blk_last !== 1'b1) begin n_fail++; $display("FAIL abc_last: got %b required 1", blk_last); end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    n_checks++;
    if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL abc_release: blk_valid got %b required 0", blk_valid); end
  endtask

  task automatic test_lengths();
    int lens[8] = '{55, 56, 63, 64, 119, 120, 128, 1};
    foreach (lens[j]) begin
      byte_t m[$];
      for (int i = 0; i < lens[j]; i++) m.push_back(byte_t'($urandom_range(255)));
      run_msg(m, 1'b0, 0, 0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      byte_t m[$];
      int len;
      len = $urandom_range(150);
      for (int i = 0; i < len; i++) m.push_back(byte_t'($urandom_range(255)));
      run_msg(m, bit'($urandom_range(1)), 30, 10);
    end
  endtask

  task automatic test_stall();
    logic [511:0] snap;
    byte_t m[$];
    beat(8'h61, 1'b1, 1'b0);
    beat(8'h62, 1'b1, 1'b0);
    beat(8'h63, 1'b1, 1'b1);
    snap = blk_data;
    in_data = 8'h55; in_keep = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks += 5;
      if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c=%0d: got %b required 1", c, blk_valid); end
      if (blk_data !== snap) begin n_fail++; $display("FAIL stall_data c=%0d: got %h required %h", c, blk_data, snap); end
      if (blk_first !== 1'b1) begin n_fail++; $display("FAIL stall_first c=%0d: got %b required 1", c, blk_first); end
      if (blk_last !== 1'b1) begin n_fail++; $display("FAIL stall_last c=%0d: got %b required 1", c, blk_last); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d: got %b required 0", c, in_ready); end
    end
    in_valid = 1'b0; in_keep = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    n_checks += 2;
    if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b required 0", blk_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b required 1", in_ready); end
    // A consumed 0x55 beat would corrupt this message.
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    run_msg(m, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    byte_t m[$];
    for (int i = 0; i < 10; i++) beat(byte_t'($urandom_range(1, 255)), 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset_mid_msg");
    @(negedge clk);
    rst = 1'b0;
    beat(8'h61, 1'b1, 1'b0);
    beat(8'h62, 1'b1, 1'b0);
    beat(8'h63, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset_mid_emit");
    @(negedge clk);
    rst = 1'b0;
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    run_msg(m, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      byte_t m[$];
      int len;
      len = $urandom_range(70);
      for (int i = 0; i < len; i++) m.push_back(byte_t'($urandom_range(255)));
      run_msg(m, 1'b0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_lengths();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
